// File: rtl/stepper_btn_conditioner_if.sv
// Button-to-command bundle between the raw button pins, the conditioner and the step sequencer.
// The master side is the conditioner; the slave side supplies buttons and consumes commands.
interface stepper_btn_conditioner_if;
  logic       btn_start_stop;
  logic       btn_direction_control;
  logic       btn_speed;
  logic       run;
  logic       dir;
  logic [1:0] speed_sel;
  logic       cmd_strobe;

  modport master (
    input  btn_start_stop,
    input  btn_direction_control,
    input  btn_speed,
    output run,
    output dir,
    output speed_sel,
    output cmd_strobe
  );

  modport slave (
    output btn_start_stop,
    output btn_direction_control,
    output btn_speed,
    input  run,
    input  dir,
    input  speed_sel,
    input  cmd_strobe
  );
endinterface

// File: rtl/stepper_btn_conditioner.sv
// Synchronises and debounces three buttons and turns clean presses into run/dir/speed commands.
// Optional macro BTN_LONG_PRESS_EN adds a 1 s start/stop hold that forces run=0 and speed_sel=0.
module stepper_btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 270000,
  parameter bit          BTN_ACTIVE_LOW     = 1'b1,
  parameter int unsigned SPEED_LEVELS       = 4,
  parameter bit          DIR_LOCK_WHILE_RUN = 1'b0
) (
  input logic                       clk,
  input logic                       rst_n,
  stepper_btn_conditioner_if.master io
);

  localparam int unsigned CntW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] RawIdle    = {3{BTN_ACTIVE_LOW}};
  localparam logic [1:0] SpeedLast  = 2'(SPEED_LEVELS - 1);

  // Bit 0 = start/stop, bit 1 = direction, bit 2 = speed.
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q, level;
  logic [1:0]      vld_q;
  logic [2:0]      stable_q, stable_prev_q, armed_q, press_q;
  logic [CntW-1:0] cnt_q [3];

  assign raw   = {io.btn_speed, io.btn_direction_control, io.btn_start_stop};
  assign level = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // A button only arms once it has been seen released after reset, so a button held through
  // reset release never produces a press event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= RawIdle;
      sync2_q       <= RawIdle;
      vld_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      armed_q       <= '0;
      press_q       <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      vld_q         <= {vld_q[0], 1'b1};
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q & armed_q;
      armed_q       <= armed_q | ({3{vld_q[1]}} & ~level);
      for (int i = 0; i < 3; i++) begin
        if (level[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          stable_q[i] <= level[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  logic long_evt;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [24:0] LongLast = 25'd26_999_999;

  logic [24:0] hold_cnt_q;
  logic        hold_done_q, long_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!stable_q[0]) begin
        hold_cnt_q  <= '0;
        hold_done_q <= 1'b0;
      end else if (!hold_done_q) begin
        if (hold_cnt_q == LongLast) begin
          long_q      <= 1'b1;
          hold_done_q <= 1'b1;
        end else begin
          hold_cnt_q <= hold_cnt_q + 25'd1;
        end
      end
    end
  end

  assign long_evt = long_q;
`else
  assign long_evt = 1'b0;
`endif

  logic       run_q, run_d, dir_q, dir_d, strobe_q, strobe_d, dir_evt;
  logic [1:0] speed_q, speed_d;

  assign dir_evt = press_q[1] & ~(DIR_LOCK_WHILE_RUN & run_q);

  always_comb begin
    run_d   = run_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    if (press_q[0]) run_d = ~run_q;
    if (dir_evt) dir_d = ~dir_q;
    if (press_q[2]) speed_d = (speed_q >= SpeedLast) ? 2'd0 : speed_q + 2'd1;
    if (long_evt) begin
      run_d   = 1'b0;
      speed_d = 2'd0;
    end
    strobe_d = long_evt | (run_d != run_q) | (dir_d != dir_q) | (speed_d != speed_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      dir_q    <= 1'b0;
      speed_q  <= 2'd0;
      strobe_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      strobe_q <= strobe_d;
    end
  end

  assign io.run        = run_q;
  assign io.dir        = dir_q;
  assign io.speed_sel  = speed_q;
  assign io.cmd_strobe = strobe_q;

endmodule

// File: doc/stepper_btn_conditioner.md
Name: stepper_btn_conditioner

Overview:
Upstream input stage for the stepper motor controller on the Tang Nano 9K. It synchronises and debounces the three raw user buttons (start/stop, direction, speed) and converts each clean press into a latched command: run, dir and a speed level. The downstream step sequencer consumes these as level signals and needs no knowledge of button timing.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive stable clocks required to accept a new button level (10 ms at 27 MHz); must be >= 2
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed
SPEED_LEVELS, 4, number of speed settings; speed_sel wraps modulo this value; range 2..4
DIR_LOCK_WHILE_RUN, 0, 1 = direction presses are ignored while run=1

Ports:
clk  input  1  system clock, 27 MHz
rst_n  input  1  asynchronous active-low reset
btn_start_stop  input  1  raw start/stop button, asynchronous to clk
btn_direction_control  input  1  raw direction button, asynchronous to clk
btn_speed  input  1  raw speed button, asynchronous to clk
run  output  1  1 = motor enabled
dir  output  1  0 = clockwise, 1 = counter-clockwise
speed_sel  output  2  current speed level, 0 = slowest
cmd_strobe  output  1  one-cycle pulse in the same cycle that run, dir or speed_sel changes value

Behaviour:
- Reset (rst_n=0, asynchronous): run=0, dir=0, speed_sel=0, cmd_strobe=0. Synchronisers, debounced levels and counters are cleared to the "released" state. No press event may be generated on reset release, even if a button is held down at that moment.
- Synchroniser: each button passes through its own 2-FF synchroniser, then is normalised to pressed=1 according to BTN_ACTIVE_LOW.
- Debounce, per button, independent:
  - stable holds the accepted level; cnt is a counter sized by $clog2(DEBOUNCE_CYCLES).
  - When the synchronised level equals stable: cnt <= 0.
  - When the level differs: cnt increments. When cnt = DEBOUNCE_CYCLES-1, stable <= the synchronised level and cnt <= 0.
  - Any bounce back to the stable level before the count completes restarts the count.
- Press event: a one-cycle internal pulse in the cycle after stable goes 0->1. A release (1->0) generates no event.
- Latency: for a clean raw edge, the output changes exactly DEBOUNCE_CYCLES+3 clocks after the first clk edge that samples the pressed level.
- Command update, registered on the press event:
  - start/stop press: run <= ~run.
  - direction press: dir <= ~dir. This press is ignored when DIR_LOCK_WHILE_RUN=1 and run=1 in that cycle.
  - speed press: speed_sel <= speed_sel+1, wrapping from SPEED_LEVELS-1 to 0. Upper bits are always 0 when SPEED_LEVELS<4.
- Simultaneous events: presses landing in the same cycle are all applied in that cycle, and cmd_strobe pulses once. The direction-lock check uses the pre-update value of run.
- Held button: produces exactly one event, however long it is held.
- Reset mid-debounce: the counter is discarded and no event is produced.

Optional Feature:
BTN_LONG_PRESS_EN
- Defined: adds a per-block 25-bit hold counter on the start/stop button. When its debounced level stays pressed for 27,000,000 consecutive clocks (1 s), the block forces run=0 and speed_sel=0 and asserts cmd_strobe for one cycle. This fires once per hold and does not retrigger until the button is released. The normal short-press toggle still occurs at the initial press.
- Undefined: no hold counter is built and long presses behave exactly like short presses.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1 and a 4-unit clock period.
- Reset release with btn_start_stop held at 0 (pressed) -> run stays 0, no cmd_strobe for 100 clocks.
- Clean press of start/stop (1->0, held 20 clocks) -> run=1 and a single cmd_strobe exactly 7 clocks after the first sampling edge; releasing produces no further change.
- Bounce: btn_speed toggles 0,1,0,1 with 2-clock spacing, then holds 0 -> exactly one increment, speed_sel 0->1.
- Five clean speed presses -> speed_sel sequence 1,2,3,0,1. With SPEED_LEVELS=3 the sequence is 1,2,0,1,2.
- Start and direction pressed in the same clock -> run and dir both toggle in the same cycle with one cmd_strobe. Repeat with DIR_LOCK_WHILE_RUN=1 and run=1 -> run goes to 0 while dir is unchanged.
- rst_n pulsed low for 1 clock while the debounce count is at 2 -> all outputs return to 0 immediately, and no event occurs after reset release.
